// File: rtl/gelato_types.sv
// Shared types for the gelato block-to-warp launch path.
package gelato_types;

  localparam int WARP_SIZE_DEF = 32;
  localparam int NUM_WARPS_DEF = 8;

  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } int3_t;

  typedef logic [$clog2(NUM_WARPS_DEF)-1:0] warp_id_t;

  typedef enum logic [1:0] {
    LAUNCH_IDLE  = 2'd0,
    LAUNCH_CALC  = 2'd1,
    LAUNCH_ISSUE = 2'd2,
    LAUNCH_WAIT  = 2'd3
  } launcher_state_e;

endpackage

// File: rtl/gelato_ifs.sv
// Block-launch and warp-launch bundles between the SM front end and the launcher.
interface gelato_init_sm_if;
  import gelato_types::*;

  logic  valid;
  addr_t pc;
  int3_t gridDim;
  int3_t blockDim;
  int3_t blockIdx;

  modport master (output valid, pc, gridDim, blockDim, blockIdx);
  modport slave  (input  valid, pc, gridDim, blockDim, blockIdx);
endinterface

interface gelato_init_warp_if;
  import gelato_types::*;

  logic        valid;
  addr_t       pc;
  logic [31:0] workers;
  int3_t       gridDim;
  int3_t       blockDim;
  int3_t       blockIdx;

  modport master_split_table (output valid, pc, workers, gridDim, blockDim, blockIdx);
  modport master_rf_arbiter  (output valid, pc, workers, gridDim, blockDim, blockIdx);
  modport slave              (input  valid, pc, workers, gridDim, blockDim, blockIdx);
endinterface

// File: rtl/gelato_warp_launcher.sv
// Splits an accepted thread block into warps, issues them in order and
// tracks their retirement so the block can be reported complete.
module gelato_warp_launcher
  import gelato_types::*;
#(
  parameter int WARP_SIZE = WARP_SIZE_DEF,
  parameter int NUM_WARPS = NUM_WARPS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  gelato_init_sm_if.slave               init_sm,
  output logic                          busy,
  gelato_init_warp_if.master_split_table init_warp_st,
  gelato_init_warp_if.master_rf_arbiter  init_warp_rf,
  output logic [$clog2(NUM_WARPS)-1:0]  warp_id,
  input  logic                          warp_ready,
  input  logic                          warp_done,
  input  logic [$clog2(NUM_WARPS)-1:0]  warp_done_id,
  output logic                          block_done,
  output logic                          launch_err
);

  localparam int ID_W        = $clog2(NUM_WARPS);
  localparam int WS_SHIFT    = $clog2(WARP_SIZE);
  localparam int MAX_THREADS = NUM_WARPS * WARP_SIZE;
  localparam int CNT_W       = $clog2(MAX_THREADS) + 1;
  localparam int WK_W        = WS_SHIFT + 1;

  localparam logic [1:0] S_IDLE  = LAUNCH_IDLE;
  localparam logic [1:0] S_CALC  = LAUNCH_CALC;
  localparam logic [1:0] S_ISSUE = LAUNCH_ISSUE;
  localparam logic [1:0] S_WAIT  = LAUNCH_WAIT;

  logic [1:0]           state;
  addr_t                pcReg;
  int3_t                gridReg;
  int3_t                blockDimReg;
  int3_t                blockIdxReg;
  logic [ID_W-1:0]      issueIdx;
  logic [ID_W-1:0]      lastIdx;
  logic [WK_W-1:0]      lastWorkers;
  logic [NUM_WARPS-1:0] activeMask;
  logic                 launchErr;

  logic                 warpValid;
  logic                 isLast;
  logic [31:0]          workersOut;
  logic                 accept;
  logic                 handshake;
  logic                 doneHit;
  logic [NUM_WARPS-1:0] setMask;
  logic [NUM_WARPS-1:0] clearMask;

  logic [63:0]          prodXY;
  logic [95:0]          prodXYZ;
  logic                 calcErr;
  logic [CNT_W-1:0]     threadsCnt;
  logic [CNT_W-1:0]     nwarps;
  logic [ID_W-1:0]      lastIdxCalc;
  logic [WK_W-1:0]      lastWorkersCalc;

  // Block geometry: thread count, warp count and the size of the tail warp.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    threadsCnt      = '0;
    nwarps          = '0;
    lastIdxCalc     = '0;
    lastWorkersCalc = '0;
    prodXY  = 64'(blockDimReg.x) * 64'(blockDimReg.y);
    prodXYZ = {32'b0, prodXY} * 96'(blockDimReg.z);
    calcErr = (prodXYZ == 96'd0) || (prodXYZ > 96'(MAX_THREADS));
    if (!calcErr) begin
      threadsCnt      = prodXYZ[CNT_W-1:0];
      nwarps          = (threadsCnt + CNT_W'(WARP_SIZE - 1)) >> WS_SHIFT;
      lastIdxCalc     = ID_W'(nwarps - CNT_W'(1));
      lastWorkersCalc = WK_W'(threadsCnt - ((nwarps - CNT_W'(1)) << WS_SHIFT));
    end
  end

  // Output decode is purely from registered state, so warp_ready/warp_done never reach valid or busy.
  assign warpValid  = (state == S_ISSUE);
  assign isLast     = (issueIdx == lastIdx);
  assign workersOut = warpValid ? (isLast ? 32'(lastWorkers) : 32'(WARP_SIZE)) : 32'd0;
  assign block_done = (state == S_WAIT) && (activeMask == '0);
  assign busy       = (state != S_IDLE) && !block_done;
  assign launch_err = launchErr;
  assign warp_id    = issueIdx;

  assign accept    = init_sm.valid && !busy;
  assign handshake = warpValid && warp_ready;
  assign doneHit   = warp_done && ((state == S_ISSUE) || (state == S_WAIT)) && activeMask[warp_done_id];
  assign setMask   = handshake ? (NUM_WARPS'(1) << issueIdx) : '0;
  assign clearMask = doneHit ? (NUM_WARPS'(1) << warp_done_id) : '0;

  assign init_warp_st.valid    = warpValid;
  assign init_warp_st.pc       = pcReg;
  assign init_warp_st.workers  = workersOut;
  assign init_warp_st.gridDim  = gridReg;
  assign init_warp_st.blockDim = blockDimReg;
  assign init_warp_st.blockIdx = blockIdxReg;

  assign init_warp_rf.valid    = warpValid;
  assign init_warp_rf.pc       = pcReg;
  assign init_warp_rf.workers  = workersOut;
  assign init_warp_rf.gridDim  = gridReg;
  assign init_warp_rf.blockDim = blockDimReg;
  assign init_warp_rf.blockIdx = blockIdxReg;

  // Capture the launch descriptor on acceptance; held for the whole block.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers carry no reset; nothing observes them until a launch loads them.
    if (accept) begin
      pcReg       <= init_sm.pc;
      gridReg     <= init_sm.gridDim;
      blockDimReg <= init_sm.blockDim;
      blockIdxReg <= init_sm.blockIdx;
    end
  end

  // Launch FSM, warp counters and the resident-warp mask.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register updates from the same pre-edge values.
    if (rst) begin
      state       <= S_IDLE;
      activeMask  <= '0;
      issueIdx    <= '0;
      lastIdx     <= '0;
      lastWorkers <= '0;
      launchErr   <= 1'b0;
    end else begin
      launchErr  <= 1'b0;
      // Clear uses the pre-edge mask, so a done for the warp issued this cycle cannot clear it.
      activeMask <= (activeMask & ~clearMask) | setMask;
      case (state)
        S_IDLE: begin
          if (accept) state <= S_CALC;
        end
        S_CALC: begin
          if (calcErr) begin
            launchErr <= 1'b1;
            state     <= S_IDLE;
          end else begin
            issueIdx    <= '0;
            lastIdx     <= lastIdxCalc;
            lastWorkers <= lastWorkersCalc;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (handshake) begin
            if (isLast) state    <= S_WAIT;
            else        issueIdx <= issueIdx + ID_W'(1);
          end
        end
        S_WAIT: begin
          // busy drops with block_done, so a new block may be accepted in the same cycle.
          if (block_done) state <= accept ? S_CALC : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gelato_warp_launcher.sv
// Directed bench for gelato_warp_launcher: table of block geometries plus
// hand-written stall and mid-block reset sequences.
module tb_gelato_warp_launcher;
  import gelato_types::*;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [2:0] warp_id;
  logic       warp_ready;
  logic       warp_done;
  logic [2:0] warp_done_id;
  logic       block_done;
  logic       launch_err;

  int checks = 0;
  int errors = 0;

  gelato_init_sm_if   smIf();
  gelato_init_warp_if stIf();
  gelato_init_warp_if rfIf();

  gelato_warp_launcher #(.WARP_SIZE(32), .NUM_WARPS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .init_sm      (smIf),
    .busy         (busy),
    .init_warp_st (stIf),
    .init_warp_rf (rfIf),
    .warp_id      (warp_id),
    .warp_ready   (warp_ready),
    .warp_done    (warp_done),
    .warp_done_id (warp_done_id),
    .block_done   (block_done),
    .launch_err   (launch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic        expErr;
    int          expWarps;
    int          expLast;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge (CALC cycle).
  task automatic startLaunch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                             input logic [31:0] pc);
    smIf.valid    = 1'b1;
    smIf.pc       = pc;
    smIf.gridDim  = '{x: 32'd4, y: 32'd2, z: 32'd1};
    smIf.blockDim = '{x: x, y: y, z: z};
    smIf.blockIdx = '{x: pc[7:0], y: 32'd1, z: 32'd0};
    step();
    smIf.valid = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int idx);
    logic [31:0] pc;
    pc = 32'h1000 + 32'(idx) * 32'h10;
    step();
    check("idle_busy", 64'(busy), 64'd0);
    startLaunch(v.x, v.y, v.z, pc);
    check("calc_valid", 64'(stIf.valid), 64'd0);
    check("calc_busy", 64'(busy), 64'd1);
    step();
    if (v.expErr) begin
      check("err_pulse", 64'(launch_err), 64'd1);
      check("err_valid", 64'(stIf.valid), 64'd0);
      step();
      check("err_pulse_end", 64'(launch_err), 64'd0);
      check("err_busy", 64'(busy), 64'd0);
      check("err_novalid", 64'(rfIf.valid), 64'd0);
    end else begin
      for (int w = 0; w < v.expWarps; w++) begin
        check("issue_valid", 64'(stIf.valid), 64'd1);
        check("issue_id", 64'(warp_id), 64'(w));
        check("issue_workers", 64'(stIf.workers), 64'((w == v.expWarps - 1) ? v.expLast : 32));
        check("issue_rf_workers", 64'(rfIf.workers), 64'((w == v.expWarps - 1) ? v.expLast : 32));
        check("issue_pc", 64'(rfIf.pc), 64'(pc));
        step();
      end
      check("wait_valid", 64'(stIf.valid), 64'd0);
      check("wait_busy", 64'(busy), 64'd1);
      check("wait_bdone", 64'(block_done), 64'd0);
      for (int w = 0; w < v.expWarps; w++) begin
        warp_done    = 1'b1;
        warp_done_id = 3'(w);
        step();
        if (w < v.expWarps - 1) check("early_bdone", 64'(block_done), 64'd0);
      end
      warp_done = 1'b0;
      check("bdone_pulse", 64'(block_done), 64'd1);
      check("bdone_busy", 64'(busy), 64'd0);
      step();
      check("bdone_end", 64'(block_done), 64'd0);
      check("post_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{x: 32'd64,  y: 32'd1, z: 32'd1, expErr: 1'b0, expWarps: 2, expLast: 32};
    vecs[1]  = '{x: 32'd10,  y: 32'd3, z: 32'd1, expErr: 1'b0, expWarps: 1, expLast: 30};
    vecs[2]  = '{x: 32'd0,   y: 32'd4, z: 32'd4, expErr: 1'b1, expWarps: 0, expLast: 0};
    vecs[3]  = '{x: 32'd257, y: 32'd1, z: 32'd1, expErr: 1'b1, expWarps: 0, expLast: 0};
    vecs[4]  = '{x: 32'd256, y: 32'd1, z: 32'd1, expErr: 1'b0, expWarps: 8, expLast: 32};
    vecs[5]  = '{x: 32'd33,  y: 32'd1, z: 32'd1, expErr: 1'b0, expWarps: 2, expLast: 1};
    vecs[6]  = '{x: 32'd16,  y: 32'd2, z: 32'd8, expErr: 1'b0, expWarps: 8, expLast: 32};
    vecs[7]  = '{x: 32'd65536, y: 32'd65536, z: 32'd2, expErr: 1'b1, expWarps: 0, expLast: 0};
    vecs[8]  = '{x: 32'h8000_0000, y: 32'd4, z: 32'h8000_0000, expErr: 1'b1, expWarps: 0, expLast: 0};
    vecs[9]  = '{x: 32'd1,   y: 32'd1, z: 32'd1, expErr: 1'b0, expWarps: 1, expLast: 1};
    vecs[10] = '{x: 32'd7,   y: 32'd5, z: 32'd3, expErr: 1'b0, expWarps: 4, expLast: 9};

    rst           = 1'b1;
    smIf.valid    = 1'b0;
    smIf.pc       = '0;
    smIf.gridDim  = '0;
    smIf.blockDim = '0;
    smIf.blockIdx = '0;
    warp_ready    = 1'b1;
    warp_done     = 1'b0;
    warp_done_id  = '0;
    repeat (3) step();
    check("rst_valid", 64'(stIf.valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bdone", 64'(block_done), 64'd0);
    check("rst_err", 64'(launch_err), 64'd0);
    check("rst_id", 64'(warp_id), 64'd0);
    check("rst_workers", 64'(stIf.workers), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) runVector(vecs[i], i);

    // Stall on warp 1 of a 96-thread block, with dones arriving during ISSUE.
    step();
    warp_ready = 1'b1;
    startLaunch(32'd96, 32'd1, 32'd1, 32'hABC0);
    step();
    check("stall_w0_valid", 64'(stIf.valid), 64'd1);
    check("stall_w0_id", 64'(warp_id), 64'd0);
    step();
    warp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 64'(stIf.valid), 64'd1);
      check("stall_id", 64'(warp_id), 64'd1);
      check("stall_workers", 64'(stIf.workers), 64'd32);
      check("stall_pc", 64'(stIf.pc), 64'h0000ABC0);
      check("stall_bdim", 64'(rfIf.blockDim.x), 64'd96);
      check("stall_busy", 64'(busy), 64'd1);
      warp_done  = (k < 2);
      warp_done_id = (k == 0) ? 3'd0 : 3'd5;
      smIf.valid = (k < 3);
      smIf.pc    = 32'hDEAD;
      step();
    end
    smIf.valid = 1'b0;
    check("stall_end_id", 64'(warp_id), 64'd1);
    warp_ready   = 1'b1;
    warp_done    = 1'b1;
    warp_done_id = 3'd1;
    step();
    warp_done = 1'b0;
    check("w2_id", 64'(warp_id), 64'd2);
    check("w2_workers", 64'(stIf.workers), 64'd32);
    check("w2_pc", 64'(stIf.pc), 64'h0000ABC0);
    step();
    check("s_wait_valid", 64'(stIf.valid), 64'd0);
    check("s_wait_bdone", 64'(block_done), 64'd0);
    warp_done    = 1'b1;
    warp_done_id = 3'd2;
    step();
    check("same_cycle_done_ignored", 64'(block_done), 64'd0);
    warp_done_id = 3'd1;
    step();
    warp_done = 1'b0;
    check("s_bdone", 64'(block_done), 64'd1);
    check("s_bdone_busy", 64'(busy), 64'd0);
    step();
    check("s_bdone_end", 64'(block_done), 64'd0);

    // Mid-block reset with two warps outstanding, then a fresh launch.
    startLaunch(32'd64, 32'd1, 32'd1, 32'h2000);
    step();
    step();
    step();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(stIf.valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_bdone", 64'(block_done), 64'd0);
    check("mid_rst_workers", 64'(stIf.workers), 64'd0);
    step();
    check("mid_rst_bdone2", 64'(block_done), 64'd0);
    runVector('{x: 32'd32, y: 32'd1, z: 32'd1, expErr: 1'b0, expWarps: 1, expLast: 32}, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
